// File: rtl/usb_pkg.sv
// Shared types and constants for the USB full-speed transmit path.
// Packet codes, PID bytes, CRC16 constants and the packetizer state set.
package usb_pkg;

   typedef enum logic [2:0] {
      PKT_NONE  = 3'd0,
      PKT_DATA0 = 3'd1,
      PKT_DATA1 = 3'd2,
      PKT_ACK   = 3'd3,
      PKT_NAK   = 3'd4,
      PKT_STALL = 3'd5
   } tx_packet_t;

   localparam logic [7:0] PID_OUT   = 8'hE1;
   localparam logic [7:0] PID_IN    = 8'h69;
   localparam logic [7:0] PID_SOF   = 8'hA5;
   localparam logic [7:0] PID_SETUP = 8'h2D;
   localparam logic [7:0] PID_DATA0 = 8'hC3;
   localparam logic [7:0] PID_DATA1 = 8'h4B;
   localparam logic [7:0] PID_ACK   = 8'hD2;
   localparam logic [7:0] PID_NAK   = 8'h5A;
   localparam logic [7:0] PID_STALL = 8'h1E;

   localparam logic [7:0]  SYNC_BYTE       = 8'h80;
   localparam logic [15:0] CRC16_POLY_REFL = 16'hA001;
   localparam logic [15:0] CRC16_INIT      = 16'hFFFF;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SYNC   = 3'd1,
      ST_PID    = 3'd2,
      ST_DATA   = 3'd3,
      ST_CRC_LO = 3'd4,
      ST_CRC_HI = 3'd5,
      ST_EOP    = 3'd6
   } state_t;

   function automatic logic [7:0] pid_byte(input tx_packet_t t);
      logic [7:0] p;
      p = 8'h00;
      case (t)
         PKT_DATA0: p = PID_DATA0;
         PKT_DATA1: p = PID_DATA1;
         PKT_ACK:   p = PID_ACK;
         PKT_NAK:   p = PID_NAK;
         PKT_STALL: p = PID_STALL;
         default:   p = 8'h00;
      endcase
      return p;
   endfunction

   function automatic logic is_data(input tx_packet_t t);
      return (t == PKT_DATA0) || (t == PKT_DATA1);
   endfunction

endpackage

// File: rtl/usb_crc16.sv
// Byte-wide CRC16 (reflected 0xA001) register, eight serial steps per byte.
// clr reloads the initial value and has priority over en.
module usb_crc16
   import usb_pkg::*;
(
   input  logic        clk,
   input  logic        n_rst,
   input  logic        clr,
   input  logic        en,
   input  logic [7:0]  din,
   output logic [15:0] crc
);

   logic [15:0] crc_q;
   logic [15:0] crc_d;
   logic [15:0] nxt;

   always_comb begin
      nxt = crc_q ^ {8'h00, din};
      for (int i = 0; i < 8; i++) begin
         if (nxt[0]) begin
            nxt = (nxt >> 1) ^ CRC16_POLY_REFL;
         end else begin
            nxt = nxt >> 1;
         end
      end
      crc_d = crc_q;
      if (clr) begin
         crc_d = CRC16_INIT;
      end else if (en) begin
         crc_d = nxt;
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         crc_q <= CRC16_INIT;
      end else begin
         crc_q <= crc_d;
      end
   end

   assign crc = crc_q;

endmodule

// File: rtl/usb_tx_packetizer.sv
// USB FS transmit packetizer: SYNC, PID, payload, CRC16, EOP request.
// CRC bytes are generated only when USB_TX_CRC16_EN is defined.
module usb_tx_packetizer
   import usb_pkg::*;
#(
   parameter int MAX_PKT_BYTES = 64,
   parameter int OCC_W         = 7
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic [2:0]       tx_packet,
   input  logic             tx_start,
   input  logic [OCC_W-1:0] buffer_occupancy,
   input  logic [7:0]       tx_data,
   output logic             get_tx_data,
   output logic [7:0]       byte_out,
   output logic             byte_valid,
   input  logic             byte_ready,
   output logic             eop_req,
   input  logic             eop_done,
   output logic             tx_busy,
   output logic             tx_done,
   output logic             tx_error
);

   localparam logic [OCC_W:0] MAX_OCC = (OCC_W+1)'(MAX_PKT_BYTES);

`ifdef USB_TX_CRC16_EN
   localparam state_t AFTER_DATA = ST_CRC_LO;
`else
   localparam state_t AFTER_DATA = ST_EOP;
`endif

   state_t           state_q, state_d;
   tx_packet_t       pkt_q, pkt_d;
   logic [OCC_W-1:0] cnt_q, cnt_d;
   logic             done_q, done_d;
   logic             err_q, err_d;

   logic legal;
   logic data_req;
   logic start_ok;
   logic hs;

`ifdef USB_TX_CRC16_EN
   logic        crc_clr;
   logic        crc_en;
   logic [15:0] crc_w;

   usb_crc16 u_crc (
      .clk   (clk),
      .n_rst (n_rst),
      .clr   (crc_clr),
      .en    (crc_en),
      .din   (tx_data),
      .crc   (crc_w)
   );
`endif

   assign legal    = (tx_packet >= 3'd1) && (tx_packet <= 3'd5);
   assign data_req = (tx_packet == 3'd1) || (tx_packet == 3'd2);
   assign start_ok = legal &&
                     (!data_req || ({1'b0, buffer_occupancy} <= MAX_OCC));

   // Valid depends on state only, so byte_ready never feeds back into it.
   assign byte_valid = (state_q == ST_SYNC)   || (state_q == ST_PID) ||
                       (state_q == ST_DATA)   ||
                       (state_q == ST_CRC_LO) || (state_q == ST_CRC_HI);
   assign hs = byte_valid && byte_ready;

   always_comb begin
      state_d     = state_q;
      pkt_d       = pkt_q;
      cnt_d       = cnt_q;
      done_d      = 1'b0;
      err_d       = 1'b0;
      byte_out    = 8'h00;
      get_tx_data = 1'b0;
      eop_req     = 1'b0;
`ifdef USB_TX_CRC16_EN
      crc_clr     = 1'b0;
      crc_en      = 1'b0;
`endif
      unique case (state_q)
         ST_IDLE: begin
            if (tx_start) begin
               if (start_ok) begin
                  pkt_d   = tx_packet_t'(tx_packet);
                  cnt_d   = data_req ? buffer_occupancy : '0;
                  state_d = ST_SYNC;
`ifdef USB_TX_CRC16_EN
                  crc_clr = 1'b1;
`endif
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         ST_SYNC: begin
            byte_out = SYNC_BYTE;
            if (hs) state_d = ST_PID;
         end
         ST_PID: begin
            byte_out = pid_byte(pkt_q);
            if (hs) begin
               if (!is_data(pkt_q)) begin
                  state_d = ST_EOP;
               end else if (cnt_q == '0) begin
                  state_d = AFTER_DATA;
               end else begin
                  state_d = ST_DATA;
               end
            end
         end
         ST_DATA: begin
            byte_out = tx_data;
            if (hs) begin
               get_tx_data = 1'b1;
               cnt_d       = cnt_q - OCC_W'(1);
`ifdef USB_TX_CRC16_EN
               crc_en      = 1'b1;
`endif
               if (cnt_q == OCC_W'(1)) state_d = AFTER_DATA;
            end
         end
`ifdef USB_TX_CRC16_EN
         ST_CRC_LO: begin
            byte_out = ~crc_w[7:0];
            if (hs) state_d = ST_CRC_HI;
         end
         ST_CRC_HI: begin
            byte_out = ~crc_w[15:8];
            if (hs) state_d = ST_EOP;
         end
`endif
         ST_EOP: begin
            eop_req = 1'b1;
            if (eop_done) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q <= ST_IDLE;
         pkt_q   <= PKT_NONE;
         cnt_q   <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pkt_q   <= pkt_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign tx_busy  = (state_q != ST_IDLE);
   assign tx_done  = done_q;
   assign tx_error = err_q;

endmodule
